vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Produces the VGA raster timing consumed by color_generation: pixel counters h_count/v_count, display enable, and the HSYNC/VSYNC pins.
- HSYNC/VSYNC are delayed by a configurable pipeline so they line up with the registered, sprite-RAM-delayed colour path.
- Also emits a one-cycle frame tick at the start of vertical blanking. Game logic (player/car position update) uses it.
- Sits in top level between the 25 MHz pixel clock and color_generation / the VGA connector.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_DELAY, 2, pipeline stages between count decode and sync pins (legal range 1..7)
SYNC_ACTIVE, 0, logic level of asserted sync (0 = active-low)

Ports:
CLK  input  1  pixel clock (25.175/25 MHz)
RST  input  1  asynchronous, active-high reset
h_count  output  10  current pixel column, 0..H_TOTAL-1
v_count  output  10  current line, 0..V_TOTAL-1
display_en  output  1  high when h_count<H_DISPLAY and v_count<V_DISPLAY
line_tick  output  1  one-cycle pulse when h_count==0
frame_tick  output  1  one-cycle pulse when h_count==0 and v_count==V_DISPLAY
VGA_HS  output  1  horizontal sync, delayed SYNC_DELAY cycles
VGA_VS  output  1  vertical sync, delayed SYNC_DELAY cycles

Behaviour:
- Derived totals: H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Reset (async, RST=1), held while RST high:
  - h_count=H_TOTAL-1, v_count=V_TOTAL-1.
  - display_en=0, line_tick=0, frame_tick=0.
  - Every sync pipeline stage and VGA_HS/VGA_VS = ~SYNC_ACTIVE (inactive).
- Consequence: the first rising CLK after RST deasserts yields h_count=0, v_count=0, display_en=1, line_tick=1.
- Counters:
  - h_count increments every cycle.
  - At H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - At v_count=V_TOTAL-1 and h_count=H_TOTAL-1, both wrap to 0 on the same edge.
  - No other wrap points; counts never exceed TOTAL-1.
- display_en, line_tick, frame_tick:
  - Registered, computed from next-count values, so they are exactly aligned with h_count/v_count in the same cycle (zero latency relative to counts).
  - No combinational path from counters to outputs.
- Raw sync decode from current counts:
  - hs_raw asserted for h_count in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vs_raw asserted for v_count in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491, for whole lines.
- Sync pipeline:
  - hs_raw/vs_raw feed a SYNC_DELAY-deep shift register; the last stage drives the pin.
  - Total latency from count value to pin = SYNC_DELAY cycles.
  - Asserted level = SYNC_ACTIVE.
- Per-frame counts (fixed): frame_tick once per frame (period H_TOTAL*V_TOTAL = 420000 cycles); line_tick once per line (period 800).
- Reset mid-frame: counters and pipeline reload immediately (async); sync pins go inactive within the same cycle; the first frame after release is complete from (0,0).

Decomposition:
- Shared constants.v already holds H_DISPLAY/V_DISPLAY. Add H_FRONT, H_SYNC, H_BACK, V_FRONT, V_SYNC, V_BACK, H_TOTAL, V_TOTAL there. Module parameters default to these.
- One natural sub-module: sync_delay_line (parameterised depth/width shift register with async reset value), instantiated once with width 2 for HS/VS.

Test Plan:
1. Reset release: hold RST 5 cycles then release -> during reset VGA_HS=VGA_VS=1, display_en=0; first edge after release h_count=0, v_count=0, display_en=1, line_tick=1.
2. Horizontal wrap: run to h_count=799, v_count=0 -> next cycle h_count=0, v_count=1, line_tick=1. display_en=0 for h_count 640..799 and 1 for 0..639.
3. HSYNC timing with SYNC_DELAY=2 -> VGA_HS low exactly for cycles where h_count is 658..753 (96 cycles) on every line.
4. VSYNC/frame: run one full frame -> frame_tick single pulse at (0,480). VGA_VS low from (2,490) through (1,492), i.e. 1600 cycles. Frame period 420000 cycles; v_count wraps 524->0 together with h_count 799->0.
5. Mid-frame reset: assert RST at (300,200) for 3 cycles -> counts immediately (799,524), VGA_HS/VS inactive during reset; after release sequence restarts at (0,0) and the frame is full-length.
6. Parameter override SYNC_DELAY=1, SYNC_ACTIVE=1 -> VGA_HS high for h_count 657..752, low otherwise; reset value of VGA_HS/VS = 0.

Source files
------------

// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: shared VGA 640x480@60 timing constants and raster helpers
package vga_sync_gen_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int   DEF_SYNC_DELAY  = 2;
    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;

    // Per-pixel raster flags registered alongside the counters.
    typedef struct packed {
        logic de;
        logic line;
        logic frame;
    } raster_flags_t;

    // True when c lies in the inclusive window [lo, hi].
    function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_sync_delay_line.sv
// sync_delay_line: DEPTH-stage, WIDTH-bit shift register with an async reset value
module sync_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    // Stage 0 takes the input, every later stage takes its predecessor.
    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    // Every stage parks at RST_VAL while reset is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stage_q <= {DEPTH{RST_VAL}};
        else       stage_q <= stage_d;
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster counters, display enable, line/frame ticks and delayed sync pins
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int   H_DISPLAY   = DEF_H_DISPLAY,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_DISPLAY   = DEF_V_DISPLAY,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter int   SYNC_DELAY  = DEF_SYNC_DELAY,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       display_en,
    output logic       line_tick,
    output logic       frame_tick,
    output logic       VGA_HS,
    output logic       VGA_VS
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_DISP   = cnt_t'(H_DISPLAY);
    localparam cnt_t V_DISP   = cnt_t'(V_DISPLAY);
    localparam cnt_t HS_FIRST = cnt_t'(H_DISPLAY + H_FRONT);
    localparam cnt_t HS_LAST  = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_FIRST = cnt_t'(V_DISPLAY + V_FRONT);
    localparam cnt_t VS_LAST  = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    cnt_t          h_q, h_d, v_q, v_d;
    raster_flags_t flags_q, flags_d;
    logic [1:0]    sync_lvl, sync_pins;

    // Next raster position: h wraps every line, v advances on that wrap and wraps at frame end.
    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + cnt_t'(1);
        v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
    end

    // Flags decode the next position so, once registered, they match the registered counts.
    always_comb begin
        flags_d.de    = (h_d < H_DISP) && (v_d < V_DISP);
        flags_d.line  = (h_d == '0);
        flags_d.frame = (h_d == '0) && (v_d == V_DISP);
    end

    // Reset parks at the last position so the first edge after release lands on (0,0).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            flags_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            flags_q <= flags_d;
        end
    end

    // Sync windows from the current counts, already at pin polarity ({vs, hs}).
    always_comb begin
        sync_lvl[0] = in_window(h_q, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        sync_lvl[1] = in_window(v_q, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Delays sync to match the registered, sprite-RAM-delayed colour path.
    sync_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .WIDTH   (2),
        .RST_VAL ({2{~SYNC_ACTIVE}})
    ) u_sync_delay (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (sync_lvl),
        .q_o   (sync_pins)
    );

    assign h_count    = h_q;
    assign v_count    = v_q;
    assign display_en = flags_q.de;
    assign line_tick  = flags_q.line;
    assign frame_tick = flags_q.frame;
    assign VGA_HS     = sync_pins[0];
    assign VGA_VS     = sync_pins[1];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of default, polarity/delay override and small-timing instances
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [9:0] dh, dv, ph, pv, sh, sv;
    logic       dde, dlt, dft, dhs, dvs;
    logic       pde, plt, pft, phs, pvs;
    logic       sde, slt, sft, shs, svs;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .CLK(clk), .RST(rst), .h_count(dh), .v_count(dv), .display_en(dde),
        .line_tick(dlt), .frame_tick(dft), .VGA_HS(dhs), .VGA_VS(dvs)
    );

    vga_sync_gen #(.SYNC_DELAY(1), .SYNC_ACTIVE(1'b1)) dut_p (
        .CLK(clk), .RST(rst), .h_count(ph), .v_count(pv), .display_en(pde),
        .line_tick(plt), .frame_tick(pft), .VGA_HS(phs), .VGA_VS(pvs)
    );

    // Small raster: 24 x 14 totals, 336-cycle frame, so vertical behaviour fits the run.
    vga_sync_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(3)
    ) dut_s (
        .CLK(clk), .RST(rst), .h_count(sh), .v_count(sv), .display_en(sde),
        .line_tick(slt), .frame_tick(sft), .VGA_HS(shs), .VGA_VS(svs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raster reference: n = cycles since the first edge after reset release.
    function automatic logic [24:0] model(input int n, input int hd, input int hf, input int hsy,
                                          input int hb, input int vd, input int vf, input int vsy,
                                          input int vb, input int dly, input logic act);
        int ht = hd + hf + hsy + hb;
        int vt = vd + vf + vsy + vb;
        int h = n % ht;
        int v = (n / ht) % vt;
        int m = n - dly;
        int hm = (m < 0) ? ht - 1 : m % ht;
        int vm = (m < 0) ? vt - 1 : (m / ht) % vt;
        logic hs = (hm >= hd + hf && hm < hd + hf + hsy) ? act : ~act;
        logic vs = (vm >= vd + vf && vm < vd + vf + vsy) ? act : ~act;
        return {10'(h), 10'(v), logic'(h < hd && v < vd), logic'(h == 0),
                logic'(h == 0 && v == vd), hs, vs};
    endfunction

    task automatic run_phase(input string ph_name, input int ncyc, input int e_hs_lo,
                             input int e_hs_hi, input int e_vs_lo, input int e_ft, input int e_lt);
        int md = 0, mp = 0, ms = 0;
        int hs_lo = 0, hs_hi = 0, vs_lo = 0, ft = 0, lt = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if ({dh, dv, dde, dlt, dft, dhs, dvs} !== model(n, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0)) md++;
            if ({ph, pv, pde, plt, pft, phs, pvs} !== model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b1)) mp++;
            if ({sh, sv, sde, slt, sft, shs, svs} !== model(n, 16, 2, 4, 2, 8, 2, 2, 2, 3, 1'b0)) ms++;
            if (dhs === 1'b0) hs_lo++;
            if (phs === 1'b1) hs_hi++;
            if (svs === 1'b0) vs_lo++;
            if (sft === 1'b1) ft++;
            if (dlt === 1'b1) lt++;
            if (n == 0) begin
                check({ph_name, " first h_count"}, dh, 0);
                check({ph_name, " first v_count"}, dv, 0);
                check({ph_name, " first display_en"}, dde, 1);
                check({ph_name, " first line_tick"}, dlt, 1);
                check({ph_name, " first frame_tick"}, dft, 0);
            end
            if (n == 639) check({ph_name, " de at h639"}, dde, 1);
            if (n == 640) check({ph_name, " de at h640"}, dde, 0);
            if (n == 799) check({ph_name, " pos before wrap"}, {dh, dv}, {10'd799, 10'd0});
            if (n == 800) check({ph_name, " pos after wrap"}, {dh, dv, dlt}, {10'd0, 10'd1, 1'b1});
            if (n == 657) check({ph_name, " hs h657"}, dhs, 1);
            if (n == 658) check({ph_name, " hs h658"}, dhs, 0);
            if (n == 753) check({ph_name, " hs h753"}, dhs, 0);
            if (n == 754) check({ph_name, " hs h754"}, dhs, 1);
            if (n == 192) check({ph_name, " small frame_tick"}, {sh, sv, sft}, {10'd0, 10'd8, 1'b1});
            if (n == 335) check({ph_name, " small last pos"}, {sh, sv}, {10'd23, 10'd13});
            if (n == 336) check({ph_name, " small frame wrap"}, {sh, sv}, {10'd0, 10'd0});
        end
        check({ph_name, " default cycle mismatches"}, md, 0);
        check({ph_name, " override cycle mismatches"}, mp, 0);
        check({ph_name, " small cycle mismatches"}, ms, 0);
        check({ph_name, " hs low cycles"}, hs_lo, e_hs_lo);
        check({ph_name, " override hs high cycles"}, hs_hi, e_hs_hi);
        check({ph_name, " small vs low cycles"}, vs_lo, e_vs_lo);
        check({ph_name, " small frame ticks"}, ft, e_ft);
        check({ph_name, " line ticks"}, lt, e_lt);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " counts"}, {dh, dv}, {10'd799, 10'd524});
        check({tag, " flags"}, {dde, dlt, dft}, 3'b000);
        check({tag, " sync pins"}, {dhs, dvs}, 2'b11);
        check({tag, " override sync pins"}, {phs, pvs}, 2'b00);
        check({tag, " small counts"}, {sh, sv}, {10'd23, 10'd13});
        check({tag, " small sync pins"}, {shs, svs}, 2'b11);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        // Stop at n=2299, where every instance has its sync pin asserted.
        run_phase("run1", 2300, 234, 235, 329, 7, 3);
        check({"pre-reset sync active"}, {dhs, phs, svs}, 3'b010);
        rst = 1'b1;
        #1;
        check_reset("async reset");
        repeat (3) @(negedge clk);
        check_reset("held reset");
        rst = 1'b0;
        run_phase("run2", 400, 0, 0, 48, 1, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
